// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: rebuilds 8x8 red/green frames from the row-multiplexed scan bus
// and publishes them with a one-cycle strobe. Optional macro: SCAN_ORDER_CHECK_EN.
module matrix_scan_capture #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_row_data,
    input  logic [7:0]  i_red_column_data,
    input  logic [7:0]  i_green_column_data,
    input  logic        i_err_clr,
    output logic [63:0] o_red_frame,
    output logic [63:0] o_green_frame,
    output logic        o_frame_valid,
    output logic [7:0]  o_frame_cnt,
    output logic [7:0]  o_rows_seen,
    output logic        o_err_multi_row,
    output logic        o_err_stall,
    output logic        o_err_order,
    output logic [1:0]  o_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_PUB  = 2'd2
    } state_t;

    localparam logic [3:0]  SETTLE  = 4'(SETTLE_CYC);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_row;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [3:0]  r_stable_cnt;
    logic [15:0] r_to_cnt;
    logic [63:0] r_sh_red;
    logic [63:0] r_sh_grn;
    logic [63:0] w_sh_red_next;
    logic [63:0] w_sh_grn_next;
    logic [3:0]  w_low_cnt;
    logic [2:0]  w_row_idx;
    logic [7:0]  w_rows_upd;
    logic        w_row_valid;
    logic        w_multi;
    logic        w_changed;
    logic        w_capture;
    logic        w_accept;
    logic        w_restart;
    logic        w_abort;
    logic        w_timeout;
    logic        w_complete;

    always_comb begin
        w_low_cnt = 4'd0;
        w_row_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_row[i]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_row_idx = 3'(i);
            end
        end
    end

    assign w_row_valid = (w_low_cnt == 4'd1);
    assign w_multi     = (w_low_cnt > 4'd1);
    // Compare the value being loaded into the input stage with the one it replaces,
    // so the capture lands SETTLE_CYC edges after the input register first loads it.
    assign w_changed   = {i_row_data, i_red_column_data, i_green_column_data} != {r_row, r_red, r_grn};
    assign w_capture   = w_row_valid && !w_changed && (r_stable_cnt == SETTLE - 4'd1);
    assign w_rows_upd  = o_rows_seen | (8'd1 << w_row_idx);
    assign w_complete  = w_accept && (w_rows_upd == 8'hFF);
    assign w_timeout   = (r_state != ST_IDLE) && !w_capture && (r_to_cnt == TO_LAST);

`ifdef SCAN_ORDER_CHECK_EN
    logic [2:0] r_last_row;
    logic       r_have_last;
    logic       r_err_order;
    logic [2:0] w_exp_row;
    logic       w_order_ok;

    assign w_exp_row  = r_last_row + 3'd1;
    assign w_order_ok = (w_row_idx == w_exp_row) || (r_have_last && (w_row_idx == r_last_row));
    assign w_accept   = w_capture && w_order_ok;
    assign w_restart  = w_capture && !w_order_ok && (w_row_idx == 3'd0);
    assign w_abort    = w_capture && !w_order_ok && (w_row_idx != 3'd0);
    assign o_err_order = r_err_order;

    // Last row starts at 7 with no history, so the only legal opener is row 0.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last_row  <= 3'd7;
            r_have_last <= 1'b0;
            r_err_order <= 1'b0;
        end else begin
            r_err_order <= (r_err_order & ~i_err_clr) | w_restart | w_abort;
            if (w_timeout || w_abort) begin
                r_last_row  <= 3'd7;
                r_have_last <= 1'b0;
            end else if (w_accept || w_restart) begin
                r_last_row  <= w_row_idx;
                r_have_last <= 1'b1;
            end
        end
    end
`else
    assign w_accept    = w_capture;
    assign w_restart   = 1'b0;
    assign w_abort     = 1'b0;
    assign o_err_order = 1'b0;
`endif

    always_comb begin
        w_sh_red_next = r_sh_red;
        w_sh_grn_next = r_sh_grn;
        if (w_accept || w_restart) begin
            w_sh_red_next[{w_row_idx, 3'b000} +: 8] = r_red;
            w_sh_grn_next[{w_row_idx, 3'b000} +: 8] = r_grn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        o_frame_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept || w_restart) begin
                    w_state_next = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (w_timeout || w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_complete) begin
                    w_state_next = ST_PUB;
                end
            end
            ST_PUB: begin
                o_frame_valid = 1'b1;
                w_state_next  = ST_ACQ;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_row           <= 8'hFF;
            r_red           <= 8'h00;
            r_grn           <= 8'h00;
            r_stable_cnt    <= 4'd0;
            r_to_cnt        <= 16'd0;
            r_sh_red        <= 64'd0;
            r_sh_grn        <= 64'd0;
            o_red_frame     <= 64'd0;
            o_green_frame   <= 64'd0;
            o_frame_cnt     <= 8'd0;
            o_rows_seen     <= 8'd0;
            o_err_multi_row <= 1'b0;
            o_err_stall     <= 1'b0;
        end else begin
            r_row <= i_row_data;
            r_red <= i_red_column_data;
            r_grn <= i_green_column_data;

            if (w_changed || !w_row_valid) begin
                r_stable_cnt <= 4'd0;
            end else if (r_stable_cnt < SETTLE) begin
                r_stable_cnt <= r_stable_cnt + 4'd1;
            end

            if ((r_state == ST_IDLE) || w_capture || w_timeout) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            r_sh_red <= w_sh_red_next;
            r_sh_grn <= w_sh_grn_next;

            if (r_state == ST_PUB || w_timeout || w_abort) begin
                o_rows_seen <= 8'd0;
            end else if (w_restart) begin
                o_rows_seen <= 8'h01;
            end else if (w_accept) begin
                o_rows_seen <= w_rows_upd;
            end

            // Frame outputs load with the completing row bypassed in, so they are
            // already valid during the frame_valid cycle.
            if (w_complete) begin
                o_red_frame   <= w_sh_red_next;
                o_green_frame <= w_sh_grn_next;
                o_frame_cnt   <= o_frame_cnt + 8'd1;
            end

            o_err_multi_row <= (o_err_multi_row & ~i_err_clr) | w_multi;
            o_err_stall     <= (o_err_stall & ~i_err_clr) | w_timeout;
        end
    end
endmodule
